// File: rtl/ucode_sequencer_if.sv
// ucode_sequencer_if: groups the decode handshake, AHB-lite control, microcode
// write port and status outputs of the microcode sequencer.
// Ports: master = sequencer side (drives ctrl/bus/status), slave = decode/bus/loader side.
interface ucode_sequencer_if #(
   parameter int CTRL_W = 20,
   parameter int ADDR_W = 5
);
   // decode handshake
   logic                inst_valid;
   logic [ADDR_W-1:0]   entry_addr;
   logic                flush;
   // AHB-lite response
   logic                hready;
   logic                hresp;
   // microcode store write port
   logic                uc_we;
   logic [ADDR_W-1:0]   uc_waddr;
   logic [CTRL_W+2:0]   uc_wdata;
   // datapath / bus / status outputs
   logic [CTRL_W-1:0]   ctrl_out;
   logic [1:0]          htrans;
   logic                hwrite;
   logic                done;
   logic                fault;
   logic                busy;
   logic [ADDR_W-1:0]   uaddr;

   modport master (
      input  inst_valid, entry_addr, flush, hready, hresp,
             uc_we, uc_waddr, uc_wdata,
      output ctrl_out, htrans, hwrite, done, fault, busy, uaddr
   );

   modport slave (
      output inst_valid, entry_addr, flush, hready, hresp,
             uc_we, uc_waddr, uc_wdata,
      input  ctrl_out, htrans, hwrite, done, fault, busy, uaddr
   );
endinterface

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: steps a writable microcode store from a decoded entry address,
// driving one control word per cycle and running AHB-lite address/data phases.
// Ports: clk, rst (sync, active-high), bus (ucode_sequencer_if.master).
// Latency: entry word executes in the cycle inst_valid is first seen; done/fault/
// htrans/hwrite are combinational. Backpressure: hready=0 holds the current phase.
module ucode_sequencer #(
   parameter int CTRL_W    = 20,
   parameter int ADDR_W    = 5,
   parameter int DEPTH     = 32,
   parameter int IDLE_ADDR = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   ucode_sequencer_if.master      bus
);
   localparam int WORD_W = CTRL_W + 3;
   localparam logic [ADDR_W-1:0] IDLE_A = ADDR_W'(IDLE_ADDR);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DPH  = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_upc, w_upc_nxt;
   logic                r_flush_pend, w_flush_pend_nxt;

   // microcode store: not reset, written only while idle
   logic [WORD_W-1:0]   r_store [DEPTH];

   logic [ADDR_W-1:0]   w_addr;
   logic [WORD_W-1:0]   w_word;
   logic                w_in_range;
   logic                w_at_end;
   logic                w_bus_rd, w_bus_wr, w_last;
   logic                w_flush_now;
   logic                w_active;

   // flush outside a data phase takes effect immediately
   assign w_flush_now = bus.flush && (r_state != S_DPH);
   assign w_active    = (r_state != S_IDLE) || bus.inst_valid;

   always_comb begin
      w_addr = IDLE_A;
      if (w_flush_now)
         w_addr = IDLE_A;
      else if (r_state == S_IDLE)
         w_addr = bus.inst_valid ? bus.entry_addr : IDLE_A;
      else
         w_addr = r_upc;
   end

   // addresses beyond DEPTH read as zero and are treated as the end of the store
   assign w_in_range = (32'(w_addr) < DEPTH);
   assign w_at_end   = (32'(w_addr) >= DEPTH - 1);
   assign w_word     = w_in_range ? r_store[w_addr] : '0;
   assign w_bus_rd   = w_word[CTRL_W+2];
   assign w_bus_wr   = w_word[CTRL_W+1];
   assign w_last     = w_word[CTRL_W];

   assign bus.ctrl_out = w_word[CTRL_W-1:0];
   assign bus.uaddr    = w_addr;
   assign bus.busy     = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (bus.uc_we && (r_state == S_IDLE) && (32'(bus.uc_waddr) < DEPTH))
         r_store[bus.uc_waddr] <= bus.uc_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_upc        <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_upc        <= w_upc_nxt;
         r_flush_pend <= w_flush_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_upc_nxt        = r_upc;
      w_flush_pend_nxt = r_flush_pend;
      bus.done         = 1'b0;
      bus.fault        = 1'b0;
      bus.htrans       = 2'b00;
      bus.hwrite       = 1'b0;

      case (r_state)
         S_IDLE, S_RUN: begin
            if (w_flush_now) begin
               w_state_nxt      = S_IDLE;
               w_flush_pend_nxt = 1'b0;
            end else if (w_active) begin
               if (w_bus_rd || w_bus_wr) begin
                  // a bus word needs a following data-phase word, so it may
                  // neither be last nor sit at the top of the store
                  if (w_last || (w_bus_rd && w_bus_wr) || w_at_end) begin
                     bus.fault   = 1'b1;
                     w_state_nxt = S_IDLE;
                  end else begin
                     bus.htrans = 2'b10;
                     bus.hwrite = w_bus_wr;
                     if (bus.hready) begin
                        w_upc_nxt   = w_addr + ADDR_W'(1);
                        w_state_nxt = S_DPH;
                     end else begin
                        w_upc_nxt   = w_addr;
                        w_state_nxt = S_RUN;
                     end
                  end
               end else if (w_last) begin
                  bus.done    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (w_at_end) begin
                  bus.fault   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_upc_nxt   = w_addr + ADDR_W'(1);
                  w_state_nxt = S_RUN;
               end
            end
         end

         S_DPH: begin
            if (bus.flush)
               w_flush_pend_nxt = 1'b1;
            if (bus.hready) begin
               if (bus.hresp) begin
                  bus.fault        = 1'b1;
                  w_state_nxt      = S_IDLE;
                  w_flush_pend_nxt = 1'b0;
               end else if (r_flush_pend || bus.flush) begin
                  // transfer finished; abandon the rest of the routine quietly
                  w_state_nxt      = S_IDLE;
                  w_flush_pend_nxt = 1'b0;
               end else if (w_last) begin
                  bus.done    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (w_at_end) begin
                  bus.fault   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_upc_nxt   = w_addr + ADDR_W'(1);
                  w_state_nxt = S_RUN;
               end
            end
         end

         default: begin
            w_state_nxt      = S_IDLE;
            w_flush_pend_nxt = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: directed vectors with hand-computed expectations for the
// microcode sequencer (zero-latency start, bus phases, wait states, faults,
// flush, write protection while busy, reset mid-transfer).
module tb_ucode_sequencer;
   localparam int CW = 20;
   localparam int AW = 5;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;

   ucode_sequencer_if #(.CTRL_W(CW), .ADDR_W(AW)) u_if ();

   ucode_sequencer #(
      .CTRL_W   (CW),
      .ADDR_W   (AW),
      .DEPTH    (32),
      .IDLE_ADDR(18)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [CW-1:0] C_IDLE = 20'hABCDE;
   localparam logic [CW-1:0] C0 = 20'h11111;
   localparam logic [CW-1:0] C1 = 20'h22222;
   localparam logic [CW-1:0] C2 = 20'h33333;
   localparam logic [CW-1:0] C3 = 20'h44444;
   localparam logic [CW-1:0] C4 = 20'h55555;
   localparam logic [CW-1:0] C5 = 20'h66666;
   localparam logic [CW-1:0] C6 = 20'h77777;
   localparam logic [CW-1:0] C7 = 20'h88888;

   function automatic logic [CW+2:0] mkw(input logic rd, input logic wr,
                                         input logic last, input logic [CW-1:0] c);
      return {rd, wr, last, c};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic uc_write(input logic [AW-1:0] a, input logic [CW+2:0] w);
      u_if.uc_we    = 1'b1;
      u_if.uc_waddr = a;
      u_if.uc_wdata = w;
      tick();
      u_if.uc_we    = 1'b0;
   endtask

   logic [5:0] hr_pat;
   int         done_cyc;

   initial begin
      n_vec  = 0;
      n_miss = 0;
      rst    = 1'b1;
      u_if.inst_valid = 1'b0;
      u_if.entry_addr = '0;
      u_if.flush      = 1'b0;
      u_if.hready     = 1'b1;
      u_if.hresp      = 1'b0;
      u_if.uc_we      = 1'b0;
      u_if.uc_waddr   = '0;
      u_if.uc_wdata   = '0;
      tick();
      tick();

      uc_write(5'd18, mkw(0, 0, 0, C_IDLE));
      uc_write(5'd4,  mkw(0, 0, 1, 20'h00001));
      uc_write(5'd0,  mkw(1, 0, 0, C0));
      uc_write(5'd1,  mkw(0, 0, 1, C1));
      uc_write(5'd2,  mkw(0, 1, 0, C2));
      uc_write(5'd3,  mkw(0, 0, 1, C3));
      uc_write(5'd24, mkw(0, 0, 0, C4));
      uc_write(5'd25, mkw(0, 0, 0, C5));
      uc_write(5'd26, mkw(0, 0, 1, C6));
      uc_write(5'd31, mkw(0, 0, 0, C7));

      // reset state
      settle();
      chk("rst_busy",   32'(u_if.busy),     0);
      chk("rst_done",   32'(u_if.done),     0);
      chk("rst_fault",  32'(u_if.fault),    0);
      chk("rst_htrans", 32'(u_if.htrans),   0);
      chk("rst_hwrite", 32'(u_if.hwrite),   0);
      chk("rst_uaddr",  32'(u_if.uaddr),    18);
      chk("rst_ctrl",   32'(u_if.ctrl_out), 32'(C_IDLE));
      tick();
      rst = 1'b0;

      // one-word routine: done in the same cycle, never busy
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd4;
      settle();
      chk("one_ctrl",  32'(u_if.ctrl_out), 32'h00001);
      chk("one_done",  32'(u_if.done),     1);
      chk("one_busy",  32'(u_if.busy),     0);
      chk("one_uaddr", 32'(u_if.uaddr),    4);
      tick();
      u_if.inst_valid = 1'b0;
      settle();
      chk("one_after_busy", 32'(u_if.busy), 0);

      // load routine, no wait states
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd0;
      settle();
      chk("ld_c0_htrans", 32'(u_if.htrans), 2);
      chk("ld_c0_hwrite", 32'(u_if.hwrite), 0);
      chk("ld_c0_done",   32'(u_if.done),   0);
      chk("ld_c0_ctrl",   32'(u_if.ctrl_out), 32'(C0));
      tick();
      settle();
      chk("ld_c1_ctrl",   32'(u_if.ctrl_out), 32'(C1));
      chk("ld_c1_done",   32'(u_if.done),   1);
      chk("ld_c1_htrans", 32'(u_if.htrans), 0);
      tick();
      u_if.inst_valid = 1'b0;
      settle();
      chk("ld_after_busy", 32'(u_if.busy), 0);

      // load routine, two wait states in each phase: done at cycle 5
      hr_pat   = 6'b100100;
      done_cyc = -1;
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd0;
      for (int c = 0; c < 20; c++) begin
         u_if.hready = (c < 6) ? hr_pat[c] : 1'b1;
         settle();
         if (c == 1) chk("ws_hold_htrans", 32'(u_if.htrans), 2);
         if (c == 4) chk("ws_dph_stall_busy", 32'(u_if.busy), 1);
         if (u_if.done) begin
            done_cyc = c;
            break;
         end
         tick();
      end
      chk("ws_done_cycle", 32'(done_cyc), 5);
      tick();
      u_if.inst_valid = 1'b0;
      u_if.hready     = 1'b1;
      settle();
      chk("ws_after_busy", 32'(u_if.busy), 0);

      // store routine with ERROR response in the data phase
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd2;
      settle();
      chk("st_htrans", 32'(u_if.htrans), 2);
      chk("st_hwrite", 32'(u_if.hwrite), 1);
      tick();
      u_if.hresp = 1'b1;
      settle();
      chk("st_err_fault", 32'(u_if.fault), 1);
      chk("st_err_done",  32'(u_if.done),  0);
      tick();
      u_if.hresp      = 1'b0;
      u_if.inst_valid = 1'b0;
      settle();
      chk("st_err_idle", 32'(u_if.busy), 0);
      chk("st_err_done_after", 32'(u_if.done), 0);

      // flush in the second cycle of a 3-word routine
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd24;
      settle();
      chk("fl_c0_ctrl", 32'(u_if.ctrl_out), 32'(C4));
      tick();
      u_if.flush = 1'b1;
      settle();
      chk("fl_htrans", 32'(u_if.htrans),   0);
      chk("fl_done",   32'(u_if.done),     0);
      chk("fl_ctrl",   32'(u_if.ctrl_out), 32'(C_IDLE));
      tick();
      u_if.flush      = 1'b0;
      u_if.inst_valid = 1'b0;
      settle();
      chk("fl_after_busy", 32'(u_if.busy), 0);

      // flush during a stalled data phase: transfer completes, no done
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd0;
      settle();
      chk("fd_htrans", 32'(u_if.htrans), 2);
      tick();
      u_if.hready = 1'b0;
      u_if.flush  = 1'b1;
      settle();
      chk("fd_stall_done", 32'(u_if.done), 0);
      chk("fd_stall_busy", 32'(u_if.busy), 1);
      tick();
      u_if.flush  = 1'b0;
      u_if.hready = 1'b1;
      settle();
      chk("fd_cmpl_done",  32'(u_if.done),  0);
      chk("fd_cmpl_fault", 32'(u_if.fault), 0);
      tick();
      u_if.inst_valid = 1'b0;
      settle();
      chk("fd_after_busy", 32'(u_if.busy), 0);

      // non-last word at the top of the store
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd31;
      settle();
      chk("end_fault", 32'(u_if.fault), 1);
      chk("end_done",  32'(u_if.done),  0);
      chk("end_uaddr", 32'(u_if.uaddr), 31);
      tick();
      u_if.inst_valid = 1'b0;
      settle();
      chk("end_after_busy", 32'(u_if.busy), 0);

      // 3-word routine, with a store write attempted while busy
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd24;
      settle();
      chk("r3_c0_done", 32'(u_if.done), 0);
      tick();
      u_if.uc_we    = 1'b1;
      u_if.uc_waddr = 5'd4;
      u_if.uc_wdata = mkw(0, 0, 1, 20'h00BAD);
      settle();
      chk("r3_c1_busy",  32'(u_if.busy),  1);
      chk("r3_c1_uaddr", 32'(u_if.uaddr), 25);
      tick();
      u_if.uc_we = 1'b0;
      settle();
      chk("r3_c2_done", 32'(u_if.done),     1);
      chk("r3_c2_ctrl", 32'(u_if.ctrl_out), 32'(C6));
      tick();
      u_if.inst_valid = 1'b0;
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd4;
      settle();
      chk("wp_ctrl", 32'(u_if.ctrl_out), 32'h00001);
      chk("wp_done", 32'(u_if.done),     1);
      tick();
      u_if.inst_valid = 1'b0;

      // reset during a stalled data phase
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd0;
      settle();
      tick();
      u_if.hready = 1'b0;
      rst         = 1'b1;
      settle();
      chk("rd_stall_busy", 32'(u_if.busy), 1);
      tick();
      rst             = 1'b0;
      u_if.hready     = 1'b1;
      u_if.inst_valid = 1'b0;
      settle();
      chk("rd_busy",   32'(u_if.busy),   0);
      chk("rd_htrans", 32'(u_if.htrans), 0);
      chk("rd_done",   32'(u_if.done),   0);
      tick();
      u_if.inst_valid = 1'b1;
      u_if.entry_addr = 5'd4;
      settle();
      chk("rd_next_done", 32'(u_if.done),     1);
      chk("rd_next_ctrl", 32'(u_if.ctrl_out), 32'h00001);
      tick();
      u_if.inst_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
